riscv_alu_issue: RTL and testbench
==================================

// Module: riscv_alu_issue
// PURPOSE
//  Issue side of the 64-bit RISCVALU control interface. Decodes an RV64 instruction into the
//  4-bit ALU control code and selects operands. Drives the external combinational ALU and
//  captures ALUOut/Zero. Returns the result downstream. Two-stage pipeline (D = decode
//  register, E = result register) with valid/ready on both sides; full throughput 1 op/cycle.
// PARAMETERS
//  XLEN      64   operand/result width; must match the ALU
//  ILEN      32   instruction width
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     upstream op present
//  in_ready     out  1     block accepts op this cycle
//  in_instr     in   ILEN  instruction word
//  in_rs1       in   XLEN  rs1 value
//  in_rs2       in   XLEN  rs2 value
//  in_imm       in   XLEN  sign-extended immediate (I/S type)
//  alu_ctl      out  4     to ALU ALUct1
//  alu_a        out  XLEN  to ALU A
//  alu_b        out  XLEN  to ALU B
//  alu_out      in   XLEN  from ALU ALUOut (combinational from alu_ctl/a/b)
//  alu_zero     in   1     from ALU Zero
//  out_valid    out  1     result present
//  out_ready    in   1     downstream accepts result
//  out_result   out  XLEN  captured ALUOut (0 when illegal)
//  out_zero     out  1     captured Zero; for BEQ = taken, for BNE = not taken
//  out_illegal  out  1     op not in supported set
// BEHAVIOUR
//  Reset (async, rst_n=0): d_valid=e_valid=0; alu_ctl=0, alu_a=alu_b=0;
//    out_result=0, out_zero=0, out_illegal=0. Reset mid-operation discards all in-flight ops.
//  Decode (opcode[6:0], funct3[14:12], funct7[31:25]) -> ctl, B-select:
//    0110011 R: 000/0000000 ADD=2; 000/0100000 SUB=6; 111 AND=0; 110 OR=1; 011 SLTU=7; B=rs2
//    0010011 I: 000 ADDI=2; 111 ANDI=0; 110 ORI=1; 011 SLTIU=7; B=imm
//    0000011 load, 0100011 store: ADD=2, B=imm (address generation)
//    1100011 branch: 000 BEQ, 001 BNE: SUB=6, B=rs2
//    anything else, incl. SLT/SLTI (010; ALU compare is unsigned): illegal.
//    Illegal: ctl=0, A=B=0, out_illegal=1, out_result=0.
//  NOR (12) is never issued. ALU code 7 is an unsigned compare.
//  Handshake: e_adv = !e_valid | out_ready; d_adv = !d_valid | e_adv; in_ready = d_adv.
//    in_valid&in_ready at edge N loads D. alu_ctl/a/b are driven from D registers in cycle N+1.
//    Edge N+1 captures alu_out/alu_zero into E; out_valid=1 from N+1.
//    Latency 2 edges, in->out.
//  Stall (out_ready=0 with e_valid=1): E, D and alu_* outputs hold stable; in_ready=0 if D is full.
//    out_* must not change while out_valid=1 and out_ready=0.
//  Simultaneous accept and drain in the same cycle is legal; there are no bubbles under
//    continuous valid/ready.
//  When D is empty, alu_* hold their last values. E is loaded only when d_valid.
// STRUCTURE
//  Package riscv_alu_pkg: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLTU=7, ALU_NOR=12;
//    OP_* opcode constants, F3_* funct3 constants, F7_SUB.
//  Sub-module riscv_alu_dec: combinational instr -> {ctl, use_imm, illegal}.
//    Pipeline registers and handshake live in this module.
// TESTING (bench instantiates RISCVALU behind this block)
//  1 ADD x: rs1=5, rs2=7, out_ready=1 -> out_valid 2 edges later, out_result=12, out_zero=0, out_illegal=0
//  2 SUB rs1=rs2=0x10 -> out_result=0, out_zero=1; BEQ with equal regs -> out_zero=1; BNE unequal -> out_zero=0
//  3 SLTIU rs1=3, imm=-1 (0xFFFF...F) -> out_result=1; SLTU rs1=-1, rs2=3 -> out_result=0
//  4 back-to-back 8 ADDIs with continuous valid/ready -> 8 results on consecutive cycles, in order
//  5 out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepted ops;
//    out_* stable; no loss or duplication after release
//  6 instr=0x0000_0000 and SLT (funct3 010) -> out_illegal=1, out_result=0;
//    rst_n low mid-stream -> out_valid=0 immediately, all outputs 0

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared constants and types for the RV64 ALU issue slice: ALU control codes,
// opcode/funct fields and the decoder result record.
package riscv_alu_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  // ALU control codes understood by the external combinational ALU
  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd6,
    ALU_SLTU = 4'd7,   // unsigned compare: result 1 when a < b
    ALU_NOR  = 4'd12   // supported by the ALU but never issued
  } alu_ctl_e;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 (instr[14:12])
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // funct7 (instr[31:25])
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Decoder output record
  typedef struct packed {
    alu_ctl_e ctl;
    logic     use_imm;   // B operand = immediate instead of rs2
    logic     illegal;   // op outside the supported set
  } dec_t;

endpackage

// File: rtl/riscv_alu_issue_if.sv
// Bundle of upstream, ALU-side and downstream signals of the issue block.
// master = the issue block; slave = its environment (producer, ALU, consumer).
interface riscv_alu_issue_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;

  modport master (
    input  in_valid, in_instr, in_rs1, in_rs2, in_imm,
    input  alu_out, alu_zero, out_ready,
    output in_ready, alu_ctl, alu_a, alu_b,
    output out_valid, out_result, out_zero, out_illegal
  );

  modport slave (
    output in_valid, in_instr, in_rs1, in_rs2, in_imm,
    output alu_out, alu_zero, out_ready,
    input  in_ready, alu_ctl, alu_a, alu_b,
    input  out_valid, out_result, out_zero, out_illegal
  );
endinterface

// File: rtl/riscv_alu_dec.sv
// Combinational RV64 decode: instruction word -> ALU control, B-select, illegal.
module riscv_alu_dec
  import riscv_alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  // Register specifiers are resolved upstream; only the operation fields matter here.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Opcode/funct decode; everything not explicitly matched stays illegal
  always_comb begin
    dec = '{ctl: ALU_AND, use_imm: 1'b0, illegal: 1'b1};
    case (op)
      OP_R: begin
        case (f3)
          F3_ADD: begin
            if (f7 == F7_ZERO)     dec = '{ctl: ALU_ADD, use_imm: 1'b0, illegal: 1'b0};
            else if (f7 == F7_SUB) dec = '{ctl: ALU_SUB, use_imm: 1'b0, illegal: 1'b0};
          end
          // Non-zero funct7 on these encodings belongs to other extensions
          F3_AND:  if (f7 == F7_ZERO) dec = '{ctl: ALU_AND,  use_imm: 1'b0, illegal: 1'b0};
          F3_OR:   if (f7 == F7_ZERO) dec = '{ctl: ALU_OR,   use_imm: 1'b0, illegal: 1'b0};
          F3_SLTU: if (f7 == F7_ZERO) dec = '{ctl: ALU_SLTU, use_imm: 1'b0, illegal: 1'b0};
          default: ;  // SLT is signed; the ALU only compares unsigned
        endcase
      end
      OP_I: begin
        case (f3)
          F3_ADD:  dec = '{ctl: ALU_ADD,  use_imm: 1'b1, illegal: 1'b0};
          F3_AND:  dec = '{ctl: ALU_AND,  use_imm: 1'b1, illegal: 1'b0};
          F3_OR:   dec = '{ctl: ALU_OR,   use_imm: 1'b1, illegal: 1'b0};
          F3_SLTU: dec = '{ctl: ALU_SLTU, use_imm: 1'b1, illegal: 1'b0};
          default: ;
        endcase
      end
      // Loads/stores only need address generation rs1 + imm
      OP_LOAD, OP_STORE: dec = '{ctl: ALU_ADD, use_imm: 1'b1, illegal: 1'b0};
      OP_BRANCH: begin
        // Zero of rs1 - rs2 gives BEQ taken / BNE not taken
        if (f3 == F3_BEQ || f3 == F3_BNE)
          dec = '{ctl: ALU_SUB, use_imm: 1'b0, illegal: 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_alu_issue.sv
// Issue side of the RV64 ALU: decode register (D) drives the external ALU,
// result register (E) captures ALUOut/Zero. valid/ready on both sides,
// 1 op/cycle, 2-edge latency.
module riscv_alu_issue
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  riscv_alu_issue_if.master bus
);

  localparam int STAGES = 2;

  // vld_pipe[1] = D holds an op, vld_pipe[2] = E holds a result
  logic [STAGES:1] vld_pipe;
  logic            e_adv;
  logic            d_adv;
  logic            acc;

  dec_t            dec;
  logic [3:0]      d_ctl;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic            d_ill;

  logic [XLEN-1:0] e_result;
  logic            e_zero;
  logic            e_ill;

  riscv_alu_dec u_dec (
    .instr (bus.in_instr[31:0]),
    .dec   (dec)
  );

  // A stage may move when its successor is empty or moving too
  assign e_adv = !vld_pipe[2] || bus.out_ready;
  assign d_adv = !vld_pipe[1] || e_adv;
  assign acc   = bus.in_valid && d_adv;

  // D and E registers; operand/control fields only load alongside a valid op,
  // so the ALU inputs hold their last values while D is empty or stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      d_ctl    <= '0;
      d_a      <= '0;
      d_b      <= '0;
      d_ill    <= 1'b0;
      e_result <= '0;
      e_zero   <= 1'b0;
      e_ill    <= 1'b0;
    end else begin
      if (e_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          // Illegal ops report a zero result regardless of the ALU output
          e_result <= d_ill ? '0 : bus.alu_out;
          e_zero   <= bus.alu_zero;
          e_ill    <= d_ill;
        end
      end
      if (d_adv) begin
        vld_pipe[1] <= acc;
        if (acc) begin
          d_ill <= dec.illegal;
          d_ctl <= dec.illegal ? 4'(ALU_AND) : 4'(dec.ctl);
          d_a   <= dec.illegal ? '0 : bus.in_rs1[XLEN-1:0];
          d_b   <= dec.illegal ? '0 : (dec.use_imm ? bus.in_imm : bus.in_rs2);
        end
      end
    end
  end

  assign bus.in_ready    = d_adv;
  assign bus.alu_ctl     = d_ctl;
  assign bus.alu_a       = d_a;
  assign bus.alu_b       = d_b;
  assign bus.out_valid   = vld_pipe[2];
  assign bus.out_result  = e_result;
  assign bus.out_zero    = e_zero;
  assign bus.out_illegal = e_ill;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed bench for riscv_alu_issue with a behavioural RISCVALU behind it.
module tb_riscv_alu_issue;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_alu_issue_if #(.XLEN(64), .ILEN(32)) bus ();

  riscv_alu_issue #(.XLEN(64), .ILEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RISCVALU
  logic [63:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctl)
      4'd0:  alu_res = bus.alu_a & bus.alu_b;
      4'd1:  alu_res = bus.alu_a | bus.alu_b;
      4'd2:  alu_res = bus.alu_a + bus.alu_b;
      4'd6:  alu_res = bus.alu_a - bus.alu_b;
      4'd7:  alu_res = {63'd0, bus.alu_a < bus.alu_b};
      4'd12: alu_res = ~(bus.alu_a | bus.alu_b);
      default: alu_res = '0;
    endcase
    bus.alu_out  = alu_res;
    bus.alu_zero = (alu_res == 64'd0);
  end

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    logic        chkz;
  } exp_t;

  exp_t sb[$];
  exp_t pend;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] enc(logic [6:0] f7, logic [2:0] f3, logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  function automatic exp_t ex(logic [63:0] res, logic zero, logic ill, logic chkz);
    ex = '{res: res, zero: zero, ill: ill, chkz: chkz};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(logic [31:0] instr, logic [63:0] rs1, logic [63:0] rs2,
                     logic [63:0] imm, exp_t e);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    pend         = e;
  endtask

  // One cycle: score handshakes just before the edge, return #1 after it
  task automatic step();
    logic fire_in, fire_out;
    exp_t e;
    #1;
    fire_in  = bus.in_valid && bus.in_ready;
    fire_out = bus.out_valid && bus.out_ready;
    if (fire_out) begin
      if (sb.size() == 0) chk("sb_extra_result", bus.out_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("sb_result", bus.out_result, e.res);
        chk("sb_illegal", bus.out_illegal, e.ill);
        if (e.chkz) chk("sb_zero", bus.out_zero, e.zero);
      end
    end
    if (fire_in) sb.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("drain_empty", sb.size(), 0);
    chk("drain_idle", bus.out_valid, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    pend          = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_alu_ctl", bus.alu_ctl, 4'd0);
    chk("rst_alu_a", bus.alu_a, 64'd0);
    chk("rst_alu_b", bus.alu_b, 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_zero", bus.out_zero, 1'b0);
    chk("rst_out_illegal", bus.out_illegal, 1'b0);
    rst_n = 1'b1;

    // 1: ADD 5+7, latency of two edges
    put(enc(7'h00, 3'b000, R), 64'd5, 64'd7, 64'd0, ex(64'd12, 1'b0, 1'b0, 1'b1));
    step();
    chk("t1_lat_edge1", bus.out_valid, 1'b0);
    chk("t1_alu_ctl", bus.alu_ctl, 4'd2);
    chk("t1_alu_a", bus.alu_a, 64'd5);
    chk("t1_alu_b", bus.alu_b, 64'd7);
    bus.in_valid = 1'b0;
    step();
    chk("t1_lat_edge2", bus.out_valid, 1'b1);
    chk("t1_result", bus.out_result, 64'd12);
    chk("t1_zero", bus.out_zero, 1'b0);
    chk("t1_illegal", bus.out_illegal, 1'b0);
    drain();

    // 2: SUB / BEQ / BNE zero flag
    put(enc(7'h20, 3'b000, R), 64'h10, 64'h10, 64'd0, ex(64'd0, 1'b1, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b000, BR), 64'h33, 64'h33, 64'd0, ex(64'd0, 1'b1, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b001, BR), 64'd1, 64'd2, 64'd0, ex(ALL1, 1'b0, 1'b0, 1'b1));
    step();
    drain();

    // 3: unsigned compares, logic ops, address generation
    put(enc(7'h00, 3'b011, I), 64'd3, 64'd0, ALL1, ex(64'd1, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b011, R), ALL1, 64'd3, 64'd0, ex(64'd0, 1'b1, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b111, I), 64'hF0F0, 64'd0, 64'h0FF0, ex(64'h00F0, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b110, R), 64'hF0, 64'h0F, 64'd0, ex(64'hFF, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b011, LD), 64'h1000, 64'd0, 64'd8, ex(64'h1008, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b011, ST), 64'h2000, 64'd0, ALL1 - 64'd7, ex(64'h1FF8, 1'b0, 1'b0, 1'b1));
    step();
    drain();

    // 4: 8 back-to-back ADDIs, one result per cycle
    for (int i = 0; i < 8; i++) begin
      put(enc(7'h00, 3'b000, I), 64'(i), 64'd0, 64'd100, ex(64'(100 + i), 1'b0, 1'b0, 1'b1));
      step();
      chk("t4_in_ready", bus.in_ready, 1'b1);
      if (i >= 1) chk("t4_no_bubble", bus.out_valid, 1'b1);
    end
    drain();

    // 5: out_ready low for 5 edges while streaming
    bus.out_ready = 1'b0;
    put(enc(7'h00, 3'b111, R), 64'hF0F0, 64'hFF00, 64'd0, ex(64'hF000, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b110, R), 64'hF0, 64'h0F, 64'd0, ex(64'hFF, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b000, I), 64'h40, 64'd0, 64'd2, ex(64'h42, 1'b0, 1'b0, 1'b1));
    for (int s = 0; s < 4; s++) begin
      chk("t5_in_ready_low", bus.in_ready, 1'b0);
      chk("t5_out_valid", bus.out_valid, 1'b1);
      chk("t5_out_hold", bus.out_result, 64'hF000);
      chk("t5_alu_ctl_hold", bus.alu_ctl, 4'd1);
      chk("t5_alu_a_hold", bus.alu_a, 64'hF0);
      if (s < 3) step();
    end
    chk("t5_queued", sb.size(), 2);
    bus.out_ready = 1'b1;
    step();
    chk("t5_c_accepted", sb.size(), 2);
    drain();
    step();
    chk("t5_no_dup", bus.out_valid, 1'b0);

    // 6: illegal encodings
    put(32'h0000_0000, 64'd55, 64'd66, 64'd77, ex(64'd0, 1'b0, 1'b1, 1'b0));
    step();
    chk("t6_ill_alu_a", bus.alu_a, 64'd0);
    chk("t6_ill_alu_b", bus.alu_b, 64'd0);
    chk("t6_ill_alu_ctl", bus.alu_ctl, 4'd0);
    put(enc(7'h00, 3'b010, R), 64'd1, 64'd2, 64'd0, ex(64'd0, 1'b0, 1'b1, 1'b0));
    step();
    put(enc(7'h00, 3'b010, I), 64'd1, 64'd0, 64'd5, ex(64'd0, 1'b0, 1'b1, 1'b0));
    step();
    drain();

    // 6b: reset mid-stream discards everything in flight
    put(enc(7'h00, 3'b000, R), 64'd9, 64'd9, 64'd0, ex(64'd18, 1'b0, 1'b0, 1'b1));
    step();
    put(enc(7'h00, 3'b110, R), 64'h3, 64'h4, 64'd0, ex(64'h7, 1'b0, 1'b0, 1'b1));
    step();
    chk("t6_pre_rst_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 1'b0);
    chk("t6_rst_result", bus.out_result, 64'd0);
    chk("t6_rst_zero", bus.out_zero, 1'b0);
    chk("t6_rst_illegal", bus.out_illegal, 1'b0);
    chk("t6_rst_alu_ctl", bus.alu_ctl, 4'd0);
    chk("t6_rst_alu_a", bus.alu_a, 64'd0);
    chk("t6_rst_alu_b", bus.alu_b, 64'd0);
    sb.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(enc(7'h20, 3'b000, R), 64'd20, 64'd5, 64'd0, ex(64'd15, 1'b0, 1'b0, 1'b1));
    step();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
